// File: rtl/riscv_multicycle_ctrl.sv
// ============================================================================
// riscv_multicycle_ctrl
//
// Control unit for a shared-memory multicycle RV32I datapath. A Moore FSM
// walks each instruction through fetch, decode, execute, memory and
// writeback. The unit also contains the ALU decoder and the immediate-format
// decoder. Unsupported opcodes latch a sticky Illegal flag, and the FSM then
// parks until reset.
//
// Parameters
//   MEM_WAIT  extra cycles spent in every memory state (FETCH, MEMREAD,
//             MEMWRITE), 0..15
//   CNT_W     width of the wait counter; must be able to hold MEM_WAIT
//
// Optional build macro
//   RISCV_MULTICYCLE_CTRL_LUI_EN  adds LUI (op 0110111) via the LUIEX state.
//                                 When the macro is undefined, LUI traps.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; also masks every write enable
//   op          opcode from the instruction register
//   funct3      instruction funct3
//   funct7b5    instruction bit 30
//   Zero        ALU zero flag, used to resolve branches
//   PCWrite     PC register enable
//   AdrSrc      memory address: 0 PC, 1 ALUOut
//   MemWrite    data memory write enable
//   IRWrite     IR / OldPC enable
//   ResultSrc   00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA     00 PC, 01 OldPC, 10 RD1, 11 zero
//   ALUSrcB     00 RD2, 01 ImmExt, 10 constant 4
//   ImmSrc      000 I, 001 S, 010 B, 011 J, 100 U
//   RegWrite    register file write enable
//   ALUControl  000 add, 001 sub, 010 and, 011 or, 101 slt
//   Illegal     sticky unsupported-opcode flag
// ============================================================================
module riscv_multicycle_ctrl #(
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic [2:0] ALUControl,
    output logic       Illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef RISCV_MULTICYCLE_CTRL_LUI_EN
    localparam logic [6:0] OP_LUI    = 7'b0110111;
`endif

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_JAL,
        S_BRANCH,
`ifdef RISCV_MULTICYCLE_CTRL_LUI_EN
        S_LUIEX,
`endif
        S_TRAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             last;
    logic             mem_state;
    logic             illegal_q;
    logic [1:0]       aluop;

    // Unmasked enables; the reset mask is applied at the port boundary.
    logic             pcw;
    logic             mwr;
    logic             irw;
    logic             rw;

    // A memory state is on its final cycle once the counter reaches MEM_WAIT.
    // With MEM_WAIT=0 every memory state is a single cycle.
    assign last      = (wait_cnt == CNT_W'(MEM_WAIT));
    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                       (state == S_MEMWRITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            // The counter only runs while a memory state is being held.
            // Leaving the state returns it to zero for the next memory access.
            if (mem_state && !last) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            // The flag is set on entry to TRAP, so it is already visible in
            // the first trapped cycle. It stays set until reset.
            if (state_next == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pcw        = 1'b0;
        mwr        = 1'b0;
        irw        = 1'b0;
        rw         = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        aluop      = 2'b00;

        case (state)
            S_FETCH: begin
                // PC + 4 goes straight to the PC through ResultSrc=ALUResult.
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (last) begin
                    irw        = 1'b1;
                    pcw        = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Compute the branch target early (OldPC + ImmExt) into ALUOut.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_next = S_MEMADR;
                    OP_RTYPE:  state_next = S_EXECR;
                    OP_ITYPE:  state_next = S_EXECI;
                    OP_JAL:    state_next = S_JAL;
                    OP_BRANCH: state_next = S_BRANCH;
`ifdef RISCV_MULTICYCLE_CTRL_LUI_EN
                    OP_LUI:    state_next = S_LUIEX;
`endif
                    default:   state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (last) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                rw         = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                // The address stays stable for the whole hold period. The
                // write strobe fires only once, on the final cycle.
                AdrSrc = 1'b1;
                if (last) begin
                    mwr        = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA    = 2'b10;
                aluop      = 2'b10;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                aluop      = 2'b10;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                rw         = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // The PC takes the target from ALUOut while the ALU forms
                // OldPC + 4 as the link value for ALUWB.
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pcw        = 1'b1;
                state_next = S_ALUWB;
            end
            S_BRANCH: begin
                // funct3[0] separates bne from beq, so it inverts the
                // taken sense of Zero.
                ALUSrcA    = 2'b10;
                aluop      = 2'b01;
                pcw        = Zero ^ funct3[0];
                state_next = S_FETCH;
            end
`ifdef RISCV_MULTICYCLE_CTRL_LUI_EN
            S_LUIEX: begin
                ALUSrcA    = 2'b11;
                ALUSrcB    = 2'b01;
                state_next = S_ALUWB;
            end
`endif
            S_TRAP: begin
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    // ALU decoder. funct7b5 selects sub only for register-register ops
    // (op[5]=1). An addi with bit 30 set must still add.
    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode directly, whatever the state.
    always_comb begin
        ImmSrc = 3'b000;
        case (op)
            OP_STORE:  ImmSrc = 3'b001;
            OP_BRANCH: ImmSrc = 3'b010;
            OP_JAL:    ImmSrc = 3'b011;
`ifdef RISCV_MULTICYCLE_CTRL_LUI_EN
            OP_LUI:    ImmSrc = 3'b100;
`endif
            default:   ImmSrc = 3'b000;
        endcase
    end

    assign PCWrite  = pcw & ~reset;
    assign MemWrite = mwr & ~reset;
    assign IRWrite  = irw & ~reset;
    assign RegWrite = rw  & ~reset;
    assign Illegal  = illegal_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// ============================================================================
// tb_riscv_multicycle_ctrl
//
// Three controllers run with MEM_WAIT = 0, 2 and 3. They share the
// instruction inputs, and each has its own reset. Only one instance runs at a
// time; the other two are held in reset. For every instruction the bench
// builds the full expected per-cycle control-word trace from the instruction
// class. It then compares the observed outputs against that trace on each
// falling edge.
//
// Control word layout (MSB..LSB):
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0], ALUSrcA[1:0],
//   ALUSrcB[1:0], ImmSrc[2:0], RegWrite, ALUControl[2:0], Illegal
// ============================================================================
module tb_riscv_multicycle_ctrl;

    localparam logic [17:0] EN_MASK = ~18'((1 << 17) | (1 << 15) | (1 << 14) | (1 << 4));

    localparam int K_ILL    = 0;
    localparam int K_LOAD   = 1;
    localparam int K_STORE  = 2;
    localparam int K_RTYPE  = 3;
    localparam int K_ITYPE  = 4;
    localparam int K_JAL    = 5;
    localparam int K_BRANCH = 6;
    localparam int K_LUI    = 7;

    logic        clk;
    logic [2:0]  rst;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic [17:0] cw [3];

    int errors = 0;
    int checks = 0;

    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic        m_f7;
    logic        m_z;
    logic [17:0] q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int MW = (g == 0) ? 0 : ((g == 1) ? 2 : 3);
        logic       pcw, adr, mwr, irw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alc;

        riscv_multicycle_ctrl #(.MEM_WAIT(MW), .CNT_W(4)) u_dut (
            .clk        (clk),
            .reset      (rst[g]),
            .op         (op),
            .funct3     (funct3),
            .funct7b5   (funct7b5),
            .Zero       (Zero),
            .PCWrite    (pcw),
            .AdrSrc     (adr),
            .MemWrite   (mwr),
            .IRWrite    (irw),
            .ResultSrc  (rs),
            .ALUSrcA    (sa),
            .ALUSrcB    (sb),
            .ImmSrc     (imm),
            .RegWrite   (rw),
            .ALUControl (alc),
            .Illegal    (ill)
        );

        assign cw[g] = {pcw, adr, mwr, irw, rs, sa, sb, imm, rw, alc, ill};
    end

    // ---------------- reference model ----------------
    function automatic int kind(input logic [6:0] o);
        case (o)
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b0110011: return K_RTYPE;
            7'b0010011: return K_ITYPE;
            7'b1101111: return K_JAL;
            7'b1100011: return K_BRANCH;
`ifdef RISCV_MULTICYCLE_CTRL_LUI_EN
            7'b0110111: return K_LUI;
`endif
            default:    return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] imm_model(input logic [6:0] o);
        case (o)
            7'b0100011: return 3'b001;
            7'b1100011: return 3'b010;
            7'b1101111: return 3'b011;
`ifdef RISCV_MULTICYCLE_CTRL_LUI_EN
            7'b0110111: return 3'b100;
`endif
            default:    return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] alu_model(input logic [1:0] aluop);
        logic [6:0] o;
        o = m_op;
        if (aluop == 2'b01) return 3'b001;
        if (aluop != 2'b10) return 3'b000;
        case (m_f3)
            3'b000:  return (m_f7 && o[5]) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [17:0] pk(input logic pcw, input logic adr,
                                       input logic mwr, input logic irw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic rw,
                                       input logic [1:0] aluop, input logic ill);
        return {pcw, adr, mwr, irw, rs, sa, sb, imm_model(m_op), rw,
                alu_model(aluop), ill};
    endfunction

    // Expected cycle-by-cycle trace of one instruction, starting at fetch.
    task automatic build(input int mw);
        q.delete();
        for (int i = 0; i <= mw; i++)
            q.push_back(pk(i == mw, 0, 0, i == mw, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0));
        q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0));
        case (kind(m_op))
            K_LOAD: begin
                q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0));
                for (int i = 0; i <= mw; i++)
                    q.push_back(pk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
                q.push_back(pk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 0));
            end
            K_STORE: begin
                q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0));
                for (int i = 0; i <= mw; i++)
                    q.push_back(pk(0, 1, i == mw, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
            end
            K_RTYPE: begin
                q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0));
                q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0));
            end
            K_ITYPE: begin
                q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0));
                q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0));
            end
            K_JAL: begin
                q.push_back(pk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00, 0));
                q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0));
            end
            K_BRANCH: begin
                q.push_back(pk(m_z ^ m_f3[0], 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 0));
            end
            K_LUI: begin
                q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b11, 2'b01, 0, 2'b00, 0));
                q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0));
            end
            default: begin
                // Parked in the trap: flag set, nothing enabled. The last
                // entry is the cycle in which reset is applied.
                for (int i = 0; i < 11; i++)
                    q.push_back(pk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 1));
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
        end
    endtask

    // Runs one instruction on instance idx. If cut >= 0, reset is asserted
    // during that cycle of the trace, and the run ends after that edge.
    task automatic run_instr(input int idx, input int mw, input logic [6:0] o,
                             input logic [2:0] f3, input logic f7, input logic z,
                             input int cut, input string name);
        int          c;
        logic [17:0] exp;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z;
        m_op = o; m_f3 = f3; m_f7 = f7; m_z = z;
        build(mw);
        c = cut;
        if (kind(o) == K_ILL) c = q.size() - 1;
        for (int i = 0; i < q.size(); i++) begin
            exp = q[i];
            if (i == c) begin
                rst[idx] = 1'b1;
                exp = exp & EN_MASK;
            end
            @(negedge clk);
            check($sformatf("%s mw%0d c%0d", name, mw, i), cw[idx], exp);
            @(posedge clk);
            #1;
            if (i == c) begin
                rst[idx] = 1'b0;
                return;
            end
        end
    endtask

    task automatic run_random(input int idx, input int mw, input int n);
        logic [6:0] legal [6];
        logic [6:0] o;
        legal = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 7) == 0) o = 7'($urandom);
            else o = legal[$urandom_range(0, 5)];
            run_instr(idx, mw, o, 3'($urandom), 1'($urandom), 1'($urandom), -1, "rand");
        end
    endtask

    initial begin
        rst = 3'b111;
        op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0;
        m_op = op; m_f3 = funct3; m_f7 = funct7b5; m_z = Zero;
        repeat (2) @(posedge clk);
        #1;
        // Held in reset: fetch selects visible, every enable masked.
        @(negedge clk);
        for (int g = 0; g < 3; g++)
            check($sformatf("reset%0d", g), cw[g],
                  pk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0));
        @(posedge clk);
        #1;

        // ---- MEM_WAIT = 0 ----
        rst[0] = 1'b0;
        run_instr(0, 0, 7'b0000011, 3'b010, 1'b0, 1'b0, -1, "lw");
        run_instr(0, 0, 7'b0100011, 3'b010, 1'b0, 1'b0, -1, "sw");
        run_instr(0, 0, 7'b0110011, 3'b000, 1'b0, 1'b0, -1, "add");
        run_instr(0, 0, 7'b0110011, 3'b000, 1'b1, 1'b0, -1, "sub");
        run_instr(0, 0, 7'b0010011, 3'b000, 1'b1, 1'b0, -1, "addi_b30");
        run_instr(0, 0, 7'b0110011, 3'b111, 1'b0, 1'b0, -1, "and");
        run_instr(0, 0, 7'b0010011, 3'b010, 1'b0, 1'b0, -1, "slti");
        run_instr(0, 0, 7'b0110011, 3'b110, 1'b0, 1'b0, -1, "or");
        run_instr(0, 0, 7'b1100011, 3'b000, 1'b0, 1'b1, -1, "beq_z1");
        run_instr(0, 0, 7'b1100011, 3'b001, 1'b0, 1'b1, -1, "bne_z1");
        run_instr(0, 0, 7'b1100011, 3'b001, 1'b0, 1'b0, -1, "bne_z0");
        run_instr(0, 0, 7'b1100011, 3'b000, 1'b0, 1'b0, -1, "beq_z0");
        run_instr(0, 0, 7'b1101111, 3'b000, 1'b0, 1'b0, -1, "jal");
        run_instr(0, 0, 7'b0110111, 3'b000, 1'b0, 1'b0, -1, "lui");
        run_instr(0, 0, 7'b1111111, 3'b000, 1'b0, 1'b0, -1, "illegal");
        run_instr(0, 0, 7'b0000011, 3'b010, 1'b0, 1'b0, -1, "lw_after_trap");
        run_random(0, 0, 40);
        rst[0] = 1'b1;

        // ---- MEM_WAIT = 2 ----
        rst[1] = 1'b0;
        run_instr(1, 2, 7'b0100011, 3'b010, 1'b0, 1'b0, -1, "sw");
        run_instr(1, 2, 7'b0000011, 3'b010, 1'b0, 1'b0, -1, "lw");
        run_instr(1, 2, 7'b1111111, 3'b000, 1'b0, 1'b0, -1, "illegal");
        run_random(1, 2, 20);
        rst[1] = 1'b1;

        // ---- MEM_WAIT = 3: reset lands on the would-be write cycle ----
        rst[2] = 1'b0;
        run_instr(2, 3, 7'b0100011, 3'b010, 1'b0, 1'b0, 9, "sw_cut");
        run_instr(2, 3, 7'b0000011, 3'b010, 1'b0, 1'b0, -1, "lw_restart");
        run_instr(2, 3, 7'b0100011, 3'b010, 1'b0, 1'b0, -1, "sw");
        run_random(2, 3, 10);
        rst[2] = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Multicycle control unit for the RV32I datapath, succeeding the single-cycle main decoder.
- Moore FSM steps each instruction through Fetch/Decode/Execute/Memory/Writeback.
- Adds configurable memory wait states, an integrated ALU decoder, beq/bne, and a sticky illegal-instruction trap.
- Sits between the instruction register (op, funct3, funct7b5) and the shared-memory multicycle datapath.

Parameters:
- MEM_WAIT, 0: extra cycles spent in each memory state (Fetch, MemRead, MemWrite); 0..15 legal.
- CNT_W, 4: width of the internal wait counter; must hold MEM_WAIT.

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high
- op  in  7  instruction opcode (from IR)
- funct3  in  3  instruction funct3
- funct7b5  in  1  instruction bit 30
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 PC, 1 ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  IR/OldPC enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- RegWrite  out  1  register file write enable
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- Illegal  out  1  sticky unsupported-opcode flag

Behaviour:
- Reset: at a clk edge with reset=1, state<=FETCH, wait counter<=0, Illegal<=0. While reset=1, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0.
- Wait counter: in FETCH, MEMREAD and MEMWRITE, the state is held until counter==MEM_WAIT. The counter increments each held cycle and clears on state exit. "Last cycle" means counter==MEM_WAIT.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=1 and PCWrite=1 on the last cycle only. Next state: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target).
  - Next by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100011 -> BRANCH.
  - Any other op -> TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB after the last cycle.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 on the last cycle only (exactly one write pulse). Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next: ALUWB.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = Zero XOR funct3[0] (funct3 000 beq, 001 bne). Next: FETCH.
- TRAP: Illegal<=1. All enables are 0. The FSM stays in TRAP until reset.
- Unlisted outputs in every state: enables 0, selects 0. ImmSrc and ALUControl are don't-care only where no consumer uses them.
- ImmSrc is combinational from op: 0000011/0010011 -> 000, 0100011 -> 001, 1100011 -> 010, 1101111 -> 011, otherwise 000.
- ALU decoder (combinational): ALUOp 00 -> add; ALUOp 01 -> sub; ALUOp 10 decodes by funct3:
  - 000 -> sub if (funct7b5 & op[5]), else add
  - 010 -> slt
  - 110 -> or
  - 111 -> and
  - others -> add
- Latency at MEM_WAIT=0: lw 5 cycles, sw 4, R/I 4, jal 4, branch 3. Each memory state adds MEM_WAIT cycles.

Optional Feature:
- Macro RISCV_MULTICYCLE_CTRL_LUI_EN.
- Defined: op 0110111 in DECODE goes to LUIEX, with ImmSrc=100, ALUSrcA=11, ALUSrcB=01, ALUOp=00; then ALUWB.
- Not defined: op 0110111 goes to TRAP. ImmSrc=100 and ALUSrcA=11 are never produced.

Test Plan:
- MEM_WAIT=0, lw (op 0000011): state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 only in cycle 5 with ResultSrc=01. IRWrite/PCWrite pulse only in cycle 1.
- MEM_WAIT=2, sw: FETCH held 3 cycles with IRWrite=1 only on the 3rd. MEMWRITE held 3 cycles with MemWrite=1 only on the 3rd. Total 8 cycles.
- BRANCH, funct3=000 with Zero=1 -> PCWrite=1. funct3=001 with Zero=1 -> PCWrite=0. funct3=001 with Zero=0 -> PCWrite=1. Next state FETCH in all cases.
- R-type, funct3=000, funct7b5=1 -> ALUControl=001 in EXECR. addi, funct3=000, funct7b5=1 -> ALUControl=000. funct3=111 -> 010.
- op 1111111 -> TRAP. Illegal=1 stays set across 10 cycles with all enables 0. reset=1 for one edge -> FETCH and Illegal=0.
- Reset asserted mid-MEMWRITE with MEM_WAIT=3 -> no MemWrite pulse; FSM restarts in FETCH with counter 0. op 0110111 -> LUIEX with the macro defined, TRAP without it.
